pakfifo_buf: RTL and testbench
==============================

// Module: pakfifo_buf
// PURPOSE
//  Elastic packet buffer for one NS link, placed between the packet producer (pakout_io) and the
//  packet consumer/checker (pakout) in the b_fifo test top. Accepts packets on a 4-phase req/ack
//  receive channel, stores them in a circular buffer and replays them in order on a 4-phase
//  req/ack send channel. Decouples producer rate from consumer rate; applies backpressure when full.
// PARAMETERS
//  PSZ   `NS_PACKET_SIZE  packet width in bits, carried unmodified
//  ASZ   `NS_ADDRESS_SIZE address field width (not interpreted; kept for link macro compatibility)
//  DSZ   `NS_DATA_SIZE    data field width (not interpreted)
//  RSZ   `NS_REDUN_SIZE   redundancy field width (not interpreted)
//  FLG   2                log2 of buffer depth; depth = 2**FLG entries (FLG >= 1)
// PORTS
//  i_clk      in   1      single clock; all logic rising-edge
//  reset      in   1      asynchronous, active-high; clears all state
//  rcv0_data  in   PSZ    incoming packet; stable while rcv0_req=1
//  rcv0_req   in   1      upstream request
//  rcv0_ack   out  1      acknowledge to upstream
//  snd0_data  out  PSZ    outgoing packet; stable while snd0_req=1
//  snd0_req   out  1      request to downstream
//  snd0_ack   in   1      downstream acknowledge
//  dbg_count  out  FLG+1  packets currently stored (0..2**FLG)
//  dbg_busy   out  1      1 when dbg_count!=0 or either channel is mid-handshake
// BEHAVIOUR
//  Reset: rcv0_ack=0, snd0_req=0, snd0_data=0, dbg_count=0, dbg_busy=0; both pointers and both FSMs
//   cleared; stored packets discarded. Reset mid-handshake drops req/ack immediately (async).
//  Storage: wr_ptr, rd_ptr each FLG+1 bits; empty = (wr_ptr==rd_ptr); full = low FLG bits equal and
//   MSBs differ. Pointers wrap modulo 2**(FLG+1); index = low FLG bits. dbg_count = wr_ptr-rd_ptr mod 2**(FLG+1).
//  Receive FSM (R_IDLE, R_HOLD):
//   R_IDLE: if rcv0_req=1 and !full -> write rcv0_data to mem[wr_ptr], wr_ptr+1, rcv0_ack<=1, go R_HOLD.
//           if full -> rcv0_ack stays 0 (backpressure); no write; retry every cycle.
//   R_HOLD: when rcv0_req=0 -> rcv0_ack<=0, go R_IDLE. Exactly one write per req pulse.
//  Send FSM (S_IDLE, S_REQ, S_DROP):
//   S_IDLE: if !empty -> snd0_data<=mem[rd_ptr], snd0_req<=1, go S_REQ.
//   S_REQ:  when snd0_ack=1 -> snd0_req<=0, rd_ptr+1, go S_DROP. snd0_data held unchanged in S_REQ.
//   S_DROP: when snd0_ack=0 -> go S_IDLE. snd0_data keeps last value (no glitch to 0).
//  Latency: packet written at edge N into an empty buffer -> snd0_req=1 after edge N+1.
//  Simultaneous write and pop in one cycle: both take effect; dbg_count unchanged.
//  Full: a pop frees a slot at edge N; a waiting rcv0_req is acked at edge N+1 (no write-through when full).
//  Depth-1 paths: wr and rd of the same slot in one cycle cannot occur (read only when !empty).
//  Ordering: strict FIFO; no drop, no duplication, data bits never altered.
//  Protocol violations (req dropped before ack, ack without req) are ignored; FSMs wait for valid edges.
// TESTING
//  T1 reset: assert reset mid-transfer (snd0_req=1, count=3) -> all outputs 0 same cycle, count=0 after release.
//  T2 single pass: send 0x0A5 with consumer acking in 1 cycle -> rcv0_ack after 1 edge, snd0_req at +2 edges, snd0_data=0x0A5.
//  T3 fill, FLG=2: consumer holds snd0_ack=0; send 5 packets -> 4 acked (count=4), 5th rcv0_req waits with ack=0.
//  T4 drain after full: release consumer -> 5th packet acked one cycle after first pop; output order 1..5 exact.
//  T5 wrap: stream 40 packets addr 1..14 cycling with random producer/consumer delays -> in-order, no loss,
//      pointers wrap >=4 times, dbg_count never exceeds 4.
//  T6 concurrent: steady state at count=2 with push and pop in the same cycle -> count stays 2, data order kept.

Source files
------------

// File: rtl/pakfifo_buf.sv
// Elastic packet buffer: 4-phase req/ack receive channel into a circular store,
// replayed in strict FIFO order on a 4-phase req/ack send channel.
module pakfifo_buf #(
    parameter int ASZ = 4,
    parameter int DSZ = 8,
    parameter int RSZ = 4,
    parameter int PSZ = ASZ + DSZ + RSZ,
    parameter int FLG = 2
) (
    input  logic           i_clk,
    input  logic           reset,
    input  logic [PSZ-1:0] rcv0_data,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    output logic [PSZ-1:0] snd0_data,
    output logic           snd0_req,
    input  logic           snd0_ack,
    output logic [FLG:0]   dbg_count,
    output logic           dbg_busy
);

    localparam int DEPTH = 2 ** FLG;

    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_HOLD = 1'b1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [FLG:0] PTR_ONE  = {{FLG{1'b0}}, 1'b1};
    localparam logic [FLG:0] PTR_ZERO = {(FLG + 1){1'b0}};

    logic [PSZ-1:0] mem [0:DEPTH-1];

    logic           rcv_state_r;
    logic [1:0]     snd_state_r;
    logic [FLG:0]   wr_ptr_r;
    logic [FLG:0]   rd_ptr_r;

    logic           rcv_state_s;
    logic [1:0]     snd_state_s;
    logic [FLG:0]   wr_ptr_s;
    logic [FLG:0]   rd_ptr_s;
    logic           rcv_ack_s;
    logic           snd_req_s;
    logic [PSZ-1:0] snd_data_s;
    logic [FLG:0]   count_s;
    logic           busy_s;
    logic           wr_en_s;
    logic           empty_s;
    logic           full_s;

    // Occupancy flags come from registered pointers, so a freed slot is seen one edge later.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[FLG-1:0] == rd_ptr_r[FLG-1:0]) && (wr_ptr_r[FLG] != rd_ptr_r[FLG]);
    end

    // Receive handshake: one write per req pulse, backpressure by withholding ack.
    always_comb begin
        rcv_state_s = rcv_state_r;
        wr_ptr_s    = wr_ptr_r;
        rcv_ack_s   = rcv0_ack;
        wr_en_s     = 1'b0;
        case (rcv_state_r)
            R_IDLE: begin
                if (rcv0_req && !full_s) begin
                    wr_en_s     = 1'b1;
                    wr_ptr_s    = wr_ptr_r + PTR_ONE;
                    rcv_ack_s   = 1'b1;
                    rcv_state_s = R_HOLD;
                end else begin
                    rcv_ack_s   = 1'b0;
                end
            end
            R_HOLD: begin
                if (!rcv0_req) begin
                    rcv_ack_s   = 1'b0;
                    rcv_state_s = R_IDLE;
                end else begin
                    rcv_ack_s   = 1'b1;
                end
            end
            default: begin
                rcv_ack_s   = 1'b0;
                rcv_state_s = R_IDLE;
            end
        endcase
    end

    // Send handshake: data is latched on request and held until the next packet is offered.
    always_comb begin
        snd_state_s = snd_state_r;
        rd_ptr_s    = rd_ptr_r;
        snd_req_s   = snd0_req;
        snd_data_s  = snd0_data;
        case (snd_state_r)
            S_IDLE: begin
                if (!empty_s) begin
                    snd_data_s  = mem[rd_ptr_r[FLG-1:0]];
                    snd_req_s   = 1'b1;
                    snd_state_s = S_REQ;
                end else begin
                    snd_req_s   = 1'b0;
                end
            end
            S_REQ: begin
                if (snd0_ack) begin
                    snd_req_s   = 1'b0;
                    rd_ptr_s    = rd_ptr_r + PTR_ONE;
                    snd_state_s = S_DROP;
                end else begin
                    snd_req_s   = 1'b1;
                end
            end
            S_DROP: begin
                snd_req_s = 1'b0;
                if (!snd0_ack) begin
                    snd_state_s = S_IDLE;
                end else begin
                    snd_state_s = S_DROP;
                end
            end
            default: begin
                snd_req_s   = 1'b0;
                snd_state_s = S_IDLE;
            end
        endcase
    end

    // Debug outputs are computed from next state so they register alongside it.
    always_comb begin
        count_s = wr_ptr_s - rd_ptr_s;
        busy_s  = (count_s != PTR_ZERO) || (rcv_state_s == R_HOLD) || (snd_state_s != S_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            rcv_state_r <= R_IDLE;
            snd_state_r <= S_IDLE;
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            rcv0_ack    <= 1'b0;
            snd0_req    <= 1'b0;
            snd0_data   <= {PSZ{1'b0}};
            dbg_count   <= PTR_ZERO;
            dbg_busy    <= 1'b0;
        end else begin
            rcv_state_r <= rcv_state_s;
            snd_state_r <= snd_state_s;
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            rcv0_ack    <= rcv_ack_s;
            snd0_req    <= snd_req_s;
            snd0_data   <= snd_data_s;
            dbg_count   <= count_s;
            dbg_busy    <= busy_s;
        end
    end

    // Packet store; contents are invalidated by the pointer reset, not cleared.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem[wr_ptr_r[FLG-1:0]] <= rcv0_data;
        end
    end

endmodule

// File: tb/tb_pakfifo_buf.sv
// Self-checking bench for pakfifo_buf: table-driven streaming plus hand-written
// reset, latency, full/backpressure and concurrent push/pop sequences.
module tb_pakfifo_buf;

    localparam int PSZ = 16;
    localparam int FLG = 2;

    typedef struct {
        logic [PSZ-1:0] data;
        int             cdly;
    } sb_t;

    typedef struct {
        logic [PSZ-1:0] data;
        int             pdly;
        int             cdly;
    } vec_t;

    logic           i_clk;
    logic           reset;
    logic [PSZ-1:0] rcv0_data;
    logic           rcv0_req;
    logic           rcv0_ack;
    logic [PSZ-1:0] snd0_data;
    logic           snd0_req;
    logic           snd0_ack;
    logic [FLG:0]   dbg_count;
    logic           dbg_busy;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_popped = 0;
    int  max_count = 0;
    bit  cons_en = 1'b0;
    sb_t sb[$];
    vec_t vecs[40];

    pakfifo_buf #(.FLG(FLG)) dut (
        .i_clk     (i_clk),
        .reset     (reset),
        .rcv0_data (rcv0_data),
        .rcv0_req  (rcv0_req),
        .rcv0_ack  (rcv0_ack),
        .snd0_data (snd0_data),
        .snd0_req  (snd0_req),
        .snd0_ack  (snd0_ack),
        .dbg_count (dbg_count),
        .dbg_busy  (dbg_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Producer: one complete 4-phase transfer, expected packet queued when driven.
    task automatic send_pkt(input logic [PSZ-1:0] d, input int cdly, input int pdly);
        sb_t e;
        int  k;
        @(negedge i_clk);
        e.data = d;
        e.cdly = cdly;
        sb.push_back(e);
        rcv0_data = d;
        rcv0_req  = 1'b1;
        k = 0;
        while (!rcv0_ack && k < 300) begin
            @(negedge i_clk);
            k++;
        end
        chk("rcv_ack_timeout", {31'd0, rcv0_ack}, 32'd1);
        rcv0_req = 1'b0;
        k = 0;
        while (rcv0_ack && k < 50) begin
            @(negedge i_clk);
            k++;
        end
        chk("rcv_ack_release", {31'd0, rcv0_ack}, 32'd0);
        for (int j = 0; j < pdly; j++) @(negedge i_clk);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || dbg_busy) && k < 2000) begin
            @(negedge i_clk);
            k++;
        end
        chk("drain_sb_empty", sb.size(), 32'd0);
        chk("drain_idle", {31'd0, dbg_busy}, 32'd0);
    endtask

    // Consumer: pops the scoreboard and compares each offered packet before acking.
    initial begin : consumer
        sb_t e;
        int  k;
        snd0_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            #1;
            if (cons_en && snd0_req && !snd0_ack && !reset) begin
                if (sb.size() == 0) begin
                    chk("unexpected_packet", {16'd0, snd0_data}, 32'hFFFF_FFFF);
                    e.cdly = 0;
                end else begin
                    e = sb.pop_front();
                    for (int j = 0; j < e.cdly; j++) @(negedge i_clk);
                    chk("snd0_data", {16'd0, snd0_data}, {16'd0, e.data});
                end
                snd0_ack = 1'b1;
                n_popped++;
                k = 0;
                while (snd0_req && k < 50) begin
                    @(negedge i_clk);
                    k++;
                end
                chk("snd_req_drop", {31'd0, snd0_req}, 32'd0);
                snd0_ack = 1'b0;
            end
        end
    end

    initial begin : occupancy_monitor
        forever begin
            @(negedge i_clk);
            if (int'(dbg_count) > max_count) max_count = int'(dbg_count);
        end
    end

    initial begin : main
        int k;
        sb_t e;
        int popped0;
        reset     = 1'b1;
        rcv0_data = '0;
        rcv0_req  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            vecs[i].data = PSZ'((i + 1) << 4) | PSZ'(1 + (i % 14));
            vecs[i].pdly = int'($urandom_range(0, 3));
            vecs[i].cdly = int'($urandom_range(0, 4));
        end
        repeat (3) @(negedge i_clk);
        chk("rst_rcv0_ack", {31'd0, rcv0_ack}, 32'd0);
        chk("rst_snd0_req", {31'd0, snd0_req}, 32'd0);
        chk("rst_snd0_data", {16'd0, snd0_data}, 32'd0);
        chk("rst_count", {29'd0, dbg_count}, 32'd0);
        chk("rst_busy", {31'd0, dbg_busy}, 32'd0);
        reset = 1'b0;

        // T2: single pass latency
        cons_en = 1'b1;
        @(negedge i_clk);
        e.data = 16'h00A5;
        e.cdly = 0;
        sb.push_back(e);
        rcv0_data = 16'h00A5;
        rcv0_req  = 1'b1;
        @(negedge i_clk);
        chk("t2_rcv_ack", {31'd0, rcv0_ack}, 32'd1);
        chk("t2_snd_req_early", {31'd0, snd0_req}, 32'd0);
        rcv0_req = 1'b0;
        @(negedge i_clk);
        chk("t2_snd_req", {31'd0, snd0_req}, 32'd1);
        chk("t2_snd_data", {16'd0, snd0_data}, 32'h00A5);
        wait_drain();

        // T3: fill with the consumer stalled
        cons_en = 1'b0;
        for (int i = 1; i <= 4; i++) send_pkt(PSZ'(i), 0, 0);
        @(negedge i_clk);
        chk("t3_count_full", {29'd0, dbg_count}, 32'd4);
        e.data = 16'd5;
        e.cdly = 0;
        sb.push_back(e);
        rcv0_data = 16'd5;
        rcv0_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("t3_backpressure", {31'd0, rcv0_ack}, 32'd0);
        end
        chk("t3_count_hold", {29'd0, dbg_count}, 32'd4);

        // T4: release consumer; fifth packet acked one edge after the first pop
        cons_en = 1'b1;
        k = 0;
        while (dbg_count != 3'd3 && k < 50) begin
            @(negedge i_clk);
            k++;
        end
        chk("t4_first_pop", {29'd0, dbg_count}, 32'd3);
        chk("t4_no_writethrough", {31'd0, rcv0_ack}, 32'd0);
        @(negedge i_clk);
        chk("t4_late_ack", {31'd0, rcv0_ack}, 32'd1);
        chk("t4_count_refill", {29'd0, dbg_count}, 32'd4);
        rcv0_req = 1'b0;
        wait_drain();

        // T6: concurrent push and pop at count 2
        cons_en = 1'b0;
        send_pkt(16'h0B01, 0, 0);
        send_pkt(16'h0B02, 0, 0);
        k = 0;
        while (!snd0_req && k < 20) begin
            @(negedge i_clk);
            k++;
        end
        chk("t6_count_pre", {29'd0, dbg_count}, 32'd2);
        e.data = 16'h0B03;
        e.cdly = 0;
        sb.push_back(e);
        rcv0_data = 16'h0B03;
        rcv0_req  = 1'b1;
        cons_en   = 1'b1;
        @(negedge i_clk);
        chk("t6_push_ack", {31'd0, rcv0_ack}, 32'd1);
        chk("t6_count_same", {29'd0, dbg_count}, 32'd2);
        rcv0_req = 1'b0;
        @(negedge i_clk);
        chk("t6_count_after", {29'd0, dbg_count}, 32'd2);
        wait_drain();

        // T5: table-driven stream with random producer/consumer pacing
        max_count = 0;
        popped0   = n_popped;
        for (int i = 0; i < 40; i++) send_pkt(vecs[i].data, vecs[i].cdly, vecs[i].pdly);
        wait_drain();
        chk("t5_popped", n_popped - popped0, 32'd40);
        chk("t5_max_count_le4", {31'd0, (max_count <= 4)}, 32'd1);

        // T1: asynchronous reset mid-transfer
        cons_en = 1'b0;
        for (int i = 1; i <= 3; i++) send_pkt(PSZ'(16'h0C00 + i), 0, 0);
        @(negedge i_clk);
        chk("t1_pre_req", {31'd0, snd0_req}, 32'd1);
        chk("t1_pre_count", {29'd0, dbg_count}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("t1_async_req", {31'd0, snd0_req}, 32'd0);
        chk("t1_async_data", {16'd0, snd0_data}, 32'd0);
        chk("t1_async_ack", {31'd0, rcv0_ack}, 32'd0);
        chk("t1_async_count", {29'd0, dbg_count}, 32'd0);
        chk("t1_async_busy", {31'd0, dbg_busy}, 32'd0);
        sb.delete();
        @(negedge i_clk);
        reset = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("t1_post_count", {29'd0, dbg_count}, 32'd0);
        chk("t1_post_req", {31'd0, snd0_req}, 32'd0);
        chk("t1_post_busy", {31'd0, dbg_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
